// File: rtl/time_load_ctrl_if.sv
// Bus between the time-load controller and its requesters / the time counter.
//   Requests : i_rx_dv/i_rx_byte (UART byte stream), i_btn_req/i_btn_ore/i_btn_minute (button set)
//   Results  : ore/minute/load/o_src (load to time counter), o_btn_ack, o_frame_err
// Modport slave is the controller; modport master is whoever drives the requests.
interface time_load_ctrl_if;
  logic       i_rx_dv;
  logic [7:0] i_rx_byte;
  logic       i_btn_req;
  logic [4:0] i_btn_ore;
  logic [5:0] i_btn_minute;
  logic [4:0] ore;
  logic [5:0] minute;
  logic       load;
  logic       o_src;
  logic       o_btn_ack;
  logic       o_frame_err;

  modport master (
    output i_rx_dv, i_rx_byte, i_btn_req, i_btn_ore, i_btn_minute,
    input  ore, minute, load, o_src, o_btn_ack, o_frame_err
  );

  modport slave (
    input  i_rx_dv, i_rx_byte, i_btn_req, i_btn_ore, i_btn_minute,
    output ore, minute, load, o_src, o_btn_ack, o_frame_err
  );
endinterface

// File: rtl/time_load_ctrl.sv
// Time-load controller: parses UART time-set frames (FF, HH, MM, FF) with an inter-byte
// timeout, arbitrates them against push-button set requests and issues a one-cycle load
// of hours/minutes to the time counter.
// Ports:
//   i_clock : system clock, rising edge
//   reset   : synchronous active-high reset
//   bus     : time_load_ctrl_if.slave (UART bytes, button request, load outputs, ack, error)
module time_load_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter bit          UART_PRIO      = 1'b1
) (
  input logic             i_clock,
  input logic             reset,
  time_load_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGetH, StGetM, StGetEnd} state_e;

  localparam int unsigned     CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      hh_q, hh_d;
  logic [5:0]      mm_q, mm_d;
  logic            pend_q, pend_d;
  logic [4:0]      pend_ore_q, pend_ore_d;
  logic [5:0]      pend_min_q, pend_min_d;
  logic            rearm_q, rearm_d;
  logic [4:0]      ore_q, ore_d;
  logic [5:0]      min_q, min_d;
  logic            load_q, load_d;
  logic            src_q, src_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic            byte_ff;
  logic            parse_err;
  logic            timeout;
  logic            end_acc;
  logic            uart_cand, btn_cand, btn_ok;
  logic            grant_uart, grant_btn;
  logic [4:0]      uart_ore;
  logic [5:0]      uart_min;

  assign byte_ff = (bus.i_rx_byte == 8'hFF);

  // Frame parser and inter-byte timeout
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hh_d      = hh_q;
    mm_d      = mm_q;
    parse_err = 1'b0;
    timeout   = 1'b0;
    end_acc   = 1'b0;
    if (bus.i_rx_dv) begin
      // A byte always beats a timeout in the same cycle.
      cnt_d = '0;
      case (state_q)
        StIdle: begin
          if (byte_ff) state_d = StGetH;
        end
        StGetH: begin
          if (byte_ff) begin
            state_d = StGetH;
          end else if (bus.i_rx_byte <= 8'd23) begin
            hh_d    = bus.i_rx_byte[4:0];
            state_d = StGetM;
          end else begin
            parse_err = 1'b1;
            state_d   = StIdle;
          end
        end
        StGetM: begin
          if (byte_ff) begin
            state_d = StGetH;
          end else if (bus.i_rx_byte <= 8'd59) begin
            mm_d    = bus.i_rx_byte[5:0];
            state_d = StGetEnd;
          end else begin
            parse_err = 1'b1;
            state_d   = StIdle;
          end
        end
        StGetEnd: begin
          if (byte_ff) begin
            end_acc = 1'b1;
          end else begin
            parse_err = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      timeout = 1'b1;
      cnt_d   = '0;
      state_d = StIdle;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Arbitration between the UART frame and the button request
  always_comb begin
    // A just-accepted end byte bypasses the pending flag; HH/MM are already latched.
    uart_cand  = pend_q | end_acc;
    uart_ore   = pend_q ? pend_ore_q : hh_q;
    uart_min   = pend_q ? pend_min_q : mm_q;
    btn_cand   = bus.i_btn_req & rearm_q;
    btn_ok     = (bus.i_btn_ore <= 5'd23) && (bus.i_btn_minute <= 6'd59);
    grant_uart = uart_cand & (~btn_cand | UART_PRIO);
    grant_btn  = btn_cand & ~grant_uart;

    ore_d      = ore_q;
    min_d      = min_q;
    load_d     = 1'b0;
    src_d      = src_q;
    ack_d      = 1'b0;
    err_d      = parse_err | timeout;
    pend_d     = pend_q;
    pend_ore_d = pend_ore_q;
    pend_min_d = pend_min_q;
    // Rearm only after the request is seen low, so a held request is granted once.
    rearm_d    = rearm_q | ~bus.i_btn_req;

    if (grant_uart) begin
      load_d = 1'b1;
      ore_d  = uart_ore;
      min_d  = uart_min;
      src_d  = 1'b0;
      pend_d = 1'b0;
    end else if (end_acc) begin
      pend_d     = 1'b1;
      pend_ore_d = hh_q;
      pend_min_d = mm_q;
    end

    if (grant_btn) begin
      ack_d   = 1'b1;
      rearm_d = 1'b0;
      // Out-of-range button values are acknowledged but never loaded.
      if (btn_ok) begin
        load_d = 1'b1;
        ore_d  = bus.i_btn_ore;
        min_d  = bus.i_btn_minute;
        src_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hh_q       <= '0;
      mm_q       <= '0;
      pend_q     <= 1'b0;
      pend_ore_q <= '0;
      pend_min_q <= '0;
      rearm_q    <= 1'b1;
      ore_q      <= '0;
      min_q      <= '0;
      load_q     <= 1'b0;
      src_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      pend_q     <= pend_d;
      pend_ore_q <= pend_ore_d;
      pend_min_q <= pend_min_d;
      rearm_q    <= rearm_d;
      ore_q      <= ore_d;
      min_q      <= min_d;
      load_q     <= load_d;
      src_q      <= src_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign bus.ore         = ore_q;
  assign bus.minute      = min_q;
  assign bus.load        = load_q;
  assign bus.o_src       = src_q;
  assign bus.o_btn_ack   = ack_q;
  assign bus.o_frame_err = err_q;

endmodule

// File: tb/tb_time_load_ctrl.sv
// Bench for time_load_ctrl: table of per-cycle vectors plus hand-written multi-cycle
// sequences (contention under both priorities, timeout, held request, mid-frame reset).
module tb_time_load_ctrl;

  logic clock;
  logic reset;

  time_load_ctrl_if bus1 ();
  time_load_ctrl_if bus0 ();

  // UART-priority and button-priority instances see identical stimulus.
  assign bus0.i_rx_dv      = bus1.i_rx_dv;
  assign bus0.i_rx_byte    = bus1.i_rx_byte;
  assign bus0.i_btn_req    = bus1.i_btn_req;
  assign bus0.i_btn_ore    = bus1.i_btn_ore;
  assign bus0.i_btn_minute = bus1.i_btn_minute;

  time_load_ctrl #(.TIMEOUT_CYCLES(100), .UART_PRIO(1'b1)) u_dut (
    .i_clock (clock),
    .reset   (reset),
    .bus     (bus1)
  );

  time_load_ctrl #(.TIMEOUT_CYCLES(100), .UART_PRIO(1'b0)) u_dut_bp (
    .i_clock (clock),
    .reset   (reset),
    .bus     (bus0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       dv;
    logic [7:0] b;
    logic       req;
    logic [4:0] bo;
    logic [5:0] bm;
    logic       ld;
    logic [4:0] o;
    logic [5:0] m;
    logic       src;
    logic       ack;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t v(logic dv, logic [7:0] b, logic req, logic [4:0] bo, logic [5:0] bm,
                             logic ld, logic [4:0] o, logic [5:0] m, logic src, logic ack,
                             logic err);
    vec_t r;
    r.dv = dv; r.b = b; r.req = req; r.bo = bo; r.bm = bm;
    r.ld = ld; r.o = o; r.m = m; r.src = src; r.ack = ack; r.err = err;
    return r;
  endfunction

  // Drive one cycle of inputs, clock once, leave time 1 unit after the edge.
  task automatic step(input logic dv, input logic [7:0] b, input logic req,
                      input logic [4:0] bo, input logic [5:0] bm);
    bus1.i_rx_dv      = dv;
    bus1.i_rx_byte    = b;
    bus1.i_btn_req    = req;
    bus1.i_btn_ore    = bo;
    bus1.i_btn_minute = bm;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 5'd0, 6'd0);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 5'd0, 6'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  int first_err, n_loads, n_acks, n_errs;

  initial begin
    // Table: per-cycle inputs and the registered response seen after that edge.
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 8'h0C, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 8'h1E, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  1, 12, 30, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,  0, 12, 30, 0, 0, 0));
    // Hours 24 rejected, then a valid frame
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 12, 30, 0, 0, 0));
    vecs.push_back(v(1, 8'h18, 0, 0, 0,  0, 12, 30, 0, 0, 1));
    vecs.push_back(v(1, 8'h05, 0, 0, 0,  0, 12, 30, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 12, 30, 0, 0, 0));
    vecs.push_back(v(1, 8'h05, 0, 0, 0,  0, 12, 30, 0, 0, 0));
    vecs.push_back(v(1, 8'h07, 0, 0, 0,  0, 12, 30, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  1, 5, 7, 0, 0, 0));
    // Resync from GET_M
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 5, 7, 0, 0, 0));
    vecs.push_back(v(1, 8'h02, 0, 0, 0,  0, 5, 7, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 5, 7, 0, 0, 0));
    vecs.push_back(v(1, 8'h08, 0, 0, 0,  0, 5, 7, 0, 0, 0));
    vecs.push_back(v(1, 8'h2D, 0, 0, 0,  0, 5, 7, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  1, 8, 45, 0, 0, 0));
    // FF in GET_H stays; 0x37 rejected as hours
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'h37, 0, 0, 0,  0, 8, 45, 0, 0, 1));
    // Minutes 60 rejected
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'h01, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'h3C, 0, 0, 0,  0, 8, 45, 0, 0, 1));
    // Bad end byte
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'h01, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'h02, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'h03, 0, 0, 0,  0, 8, 45, 0, 0, 1));
    // Boundary 23:59 over UART
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'h17, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'h3B, 0, 0, 0,  0, 8, 45, 0, 0, 0));
    vecs.push_back(v(1, 8'hFF, 0, 0, 0,  1, 23, 59, 0, 0, 0));
    // Button path
    vecs.push_back(v(0, 8'h00, 1, 9, 15,  1, 9, 15, 1, 1, 0));
    vecs.push_back(v(0, 8'h00, 1, 9, 15,  0, 9, 15, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,   0, 9, 15, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 1, 5'h1F, 0, 0, 9, 15, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,   0, 9, 15, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 1, 0, 0,   1, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 1, 23, 59, 1, 23, 59, 1, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,   0, 23, 59, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 1, 24, 0,  0, 23, 59, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,   0, 23, 59, 0, 0, 0));
    vecs.push_back(v(0, 8'h00, 1, 1, 60,  0, 23, 59, 0, 1, 0));
    vecs.push_back(v(0, 8'h00, 0, 0, 0,   0, 23, 59, 0, 0, 0));

    // Reset state
    reset = 1'b1;
    bus1.i_rx_dv = 1'b0; bus1.i_rx_byte = 8'h00; bus1.i_btn_req = 1'b0;
    bus1.i_btn_ore = 5'd0; bus1.i_btn_minute = 6'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_outputs", {bus1.ore, bus1.minute, bus1.load, bus1.o_src, bus1.o_btn_ack,
                          bus1.o_frame_err}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].dv, vecs[i].b, vecs[i].req, vecs[i].bo, vecs[i].bm);
      n_vec++;
      if (bus1.load !== vecs[i].ld || bus1.ore !== vecs[i].o || bus1.minute !== vecs[i].m ||
          bus1.o_btn_ack !== vecs[i].ack || bus1.o_frame_err !== vecs[i].err ||
          (vecs[i].ld && bus1.o_src !== vecs[i].src)) begin
        n_err++;
        $display("FAIL vec%0d: got ld=%b o=%0d m=%0d src=%b ack=%b err=%b expected ld=%b o=%0d m=%0d src=%b ack=%b err=%b",
                 i, bus1.load, bus1.ore, bus1.minute, bus1.o_src, bus1.o_btn_ack,
                 bus1.o_frame_err, vecs[i].ld, vecs[i].o, vecs[i].m, vecs[i].src,
                 vecs[i].ack, vecs[i].err);
      end
    end

    // Contention: end FF and button request in the same cycle
    send(8'hFF); send(8'h01); send(8'h02);
    step(1'b1, 8'hFF, 1'b1, 5'd9, 6'd15);
    chk("uprio_first", {bus1.load, bus1.o_src, bus1.o_btn_ack, 3'd0, bus1.ore, bus1.minute},
        {1'b1, 1'b0, 1'b0, 3'd0, 5'd1, 6'd2});
    chk("bprio_first", {bus0.load, bus0.o_src, bus0.o_btn_ack, 3'd0, bus0.ore, bus0.minute},
        {1'b1, 1'b1, 1'b1, 3'd0, 5'd9, 6'd15});
    step(1'b0, 8'h00, 1'b1, 5'd9, 6'd15);
    chk("uprio_second", {bus1.load, bus1.o_src, bus1.o_btn_ack, 3'd0, bus1.ore, bus1.minute},
        {1'b1, 1'b1, 1'b1, 3'd0, 5'd9, 6'd15});
    chk("bprio_second", {bus0.load, bus0.o_src, bus0.o_btn_ack, 3'd0, bus0.ore, bus0.minute},
        {1'b1, 1'b0, 1'b0, 3'd0, 5'd1, 6'd2});
    idle();
    chk("contention_done", {bus1.load, bus0.load, bus1.o_btn_ack, bus0.o_btn_ack}, 32'd0);

    // Held request: exactly one ack and one load
    n_loads = 0; n_acks = 0;
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 8'h00, 1'b1, 5'd3, 6'd4);
      n_loads += int'(bus1.load);
      n_acks  += int'(bus1.o_btn_ack);
    end
    idle();
    chk("held_req_acks", n_acks, 1);
    chk("held_req_loads", n_loads, 1);
    chk("held_req_value", {bus1.ore, bus1.minute}, {5'd3, 6'd4});

    // Inter-byte gap of 99 idle cycles must not time out
    n_errs = 0; n_loads = 0;
    send(8'hFF);
    for (int k = 0; k < 99; k++) begin idle(); n_errs += int'(bus1.o_frame_err); end
    send(8'h06);
    for (int k = 0; k < 99; k++) begin idle(); n_errs += int'(bus1.o_frame_err); end
    send(8'h07);
    for (int k = 0; k < 99; k++) begin idle(); n_errs += int'(bus1.o_frame_err); end
    send(8'hFF);
    chk("gap99_load", {bus1.load, bus1.ore, bus1.minute}, {1'b1, 5'd6, 6'd7});
    chk("gap99_no_err", n_errs, 0);

    // Timeout after 100 idle cycles
    first_err = 0; n_errs = 0; n_loads = 0;
    send(8'hFF); send(8'h03);
    for (int k = 1; k <= 105; k++) begin
      idle();
      if (bus1.o_frame_err === 1'b1) begin
        n_errs++;
        if (first_err == 0) first_err = k;
      end
      n_loads += int'(bus1.load);
    end
    chk("timeout_cycle", first_err, 100);
    chk("timeout_pulses", n_errs, 1);
    chk("timeout_no_load", n_loads, 0);
    send(8'hFF); send(8'h04); send(8'h05); send(8'hFF);
    chk("after_timeout_load", {bus1.load, bus1.o_src, bus1.ore, bus1.minute},
        {1'b1, 1'b0, 5'd4, 6'd5});

    // Reset mid-frame
    send(8'hFF); send(8'h01);
    reset = 1'b1;
    idle();
    chk("midframe_reset_outputs", {bus1.ore, bus1.minute, bus1.load, bus1.o_src,
                                   bus1.o_btn_ack, bus1.o_frame_err}, 32'd0);
    reset = 1'b0;
    n_errs = 0; n_loads = 0;
    // Parser must be idle: these bytes are ignored and the FF only opens a frame.
    send(8'h05); n_errs += int'(bus1.o_frame_err); n_loads += int'(bus1.load);
    send(8'h06); n_errs += int'(bus1.o_frame_err); n_loads += int'(bus1.load);
    send(8'hFF); n_errs += int'(bus1.o_frame_err); n_loads += int'(bus1.load);
    idle();      n_errs += int'(bus1.o_frame_err); n_loads += int'(bus1.load);
    chk("midframe_no_err", n_errs, 0);
    chk("midframe_no_load", n_loads, 0);
    send(8'h07); send(8'h08); send(8'hFF);
    chk("after_reset_load", {bus1.load, bus1.ore, bus1.minute}, {1'b1, 5'd7, 6'd8});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
